// File: rtl/i2c_fram_target.sv
// I2C target emulating a 2 KB FM24CL16-style FRAM: device select, word address, burst write,
// auto-incrementing reads. The bus is oversampled on clk; SDA only moves HOLD_CYCLES clk after SCL falls.
module i2c_fram_target #(
  parameter logic [3:0]  DEV_TYPE    = 4'b1010,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  output logic        busy,
  output logic        wr_strobe,
  output logic [10:0] ptr
);

  typedef enum logic [3:0] {
    IDLE, DEV_SEL, ACK_DEV, WORD_ADDR, ACK_WORD,
    WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  logic          scl_s1_q, scl_s2_q, scl_p_q;
  logic          sda_s1_q, sda_s2_q, sda_p_q;
  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          ack_half_q, ack_half_d;
  logic [10:0]   ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          sda_t_q, sda_t_d;
  logic          pend_q, pend_d;
  logic          pend_val_q, pend_val_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]    mem_q [2048];

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       last_bit, dev_match;
  logic [7:0] rx_byte, rd_byte;
  logic       mem_we, wr_en;
  logic       drive_req, drive_val;

  assign scl_rise  = scl_s2_q & ~scl_p_q;
  assign scl_fall  = ~scl_s2_q & scl_p_q;
  assign start_det = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;

  assign last_bit  = (bit_cnt_q == 3'd7);
  assign rx_byte   = {shift_q[6:0], sda_s2_q};
  assign dev_match = (rx_byte[7:4] == DEV_TYPE);
  assign rd_byte   = mem_q[ptr_q];
  assign wr_en     = mem_we & rst;

  assign sda_o     = 1'b0;
  assign sda_t     = sda_t_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_en;
  assign ptr       = ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // START/STOP override any bit-level progress, including a half-received byte.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = DEV_SEL;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        DEV_SEL:   if (scl_rise && last_bit) state_d = dev_match ? ACK_DEV : WAIT_STOP;
        ACK_DEV:   if (scl_fall && ack_half_q) state_d = shift_q[0] ? RD_DATA : WORD_ADDR;
        WORD_ADDR: if (scl_rise && last_bit) state_d = ACK_WORD;
        ACK_WORD:  if (scl_fall && ack_half_q) state_d = WR_DATA;
        WR_DATA:   if (scl_rise && last_bit) state_d = ACK_WR;
        ACK_WR:    if (scl_fall && ack_half_q) state_d = WR_DATA;
        RD_DATA:   if (scl_rise && last_bit) state_d = RD_ACK;
        RD_ACK:    if (scl_rise) state_d = sda_s2_q ? WAIT_STOP : RD_DATA;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    ack_half_d = ack_half_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    mem_we     = 1'b0;
    drive_req  = 1'b0;
    drive_val  = 1'b1;

    if (start_det || stop_det) begin
      shift_d    = 8'h00;
      bit_cnt_d  = 3'd0;
      ack_half_d = 1'b0;
      if (stop_det) busy_d = 1'b0;
    end else begin
      case (state_q)
        DEV_SEL, WORD_ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (state_q == DEV_SEL) begin
                busy_d = dev_match;
                if (dev_match) ptr_d[10:8] = rx_byte[3:1];
              end else if (state_q == WORD_ADDR) begin
                ptr_d[7:0] = rx_byte;
              end else begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 11'd1;
              end
            end
          end
        end
        // First SCL fall ends bit 8 and starts the ACK; the second ends the ACK bit.
        ACK_DEV, ACK_WORD, ACK_WR: begin
          if (scl_fall) begin
            drive_req  = 1'b1;
            ack_half_d = ~ack_half_q;
            if (!ack_half_q) begin
              drive_val = 1'b0;
            end else if (state_q == ACK_DEV && shift_q[0]) begin
              shift_d   = rd_byte;
              drive_val = rd_byte[7];
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            drive_req = 1'b1;
            if (bit_cnt_q == 3'd0) begin
              shift_d   = rd_byte;
              drive_val = rd_byte[7];
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              drive_val = shift_q[6];
            end
          end
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) ptr_d = ptr_q + 11'd1;
          end
        end
        RD_ACK: begin
          if (scl_fall) drive_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Every SDA change is deferred HOLD_CYCLES clk past the detected SCL fall.
  always_comb begin
    sda_t_d    = sda_t_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    hold_cnt_d = hold_cnt_q;
    if (start_det || stop_det) begin
      pend_d  = 1'b0;
      sda_t_d = 1'b1;
    end else if (drive_req) begin
      pend_d     = 1'b1;
      pend_val_d = drive_val;
      hold_cnt_d = HOLD_LOAD;
    end else if (pend_q) begin
      if (hold_cnt_q == '0) begin
        sda_t_d = pend_val_q;
        pend_d  = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_p_q    <= 1'b1;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      ack_half_q <= 1'b0;
      ptr_q      <= 11'd0;
      busy_q     <= 1'b0;
      sda_t_q    <= 1'b1;
      pend_q     <= 1'b0;
      pend_val_q <= 1'b1;
      hold_cnt_q <= '0;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_p_q    <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_p_q    <= sda_s2_q;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ack_half_q <= ack_half_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      sda_t_q    <= sda_t_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q] <= rx_byte;
  end

endmodule

// File: tb/tb_i2c_fram_target.sv
// Directed plus randomized bus transactions checked against a byte-array model of the FRAM.
module tb_i2c_fram_target;
  localparam int Q    = 8;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_o, sda_t, busy, wr_strobe;
  logic [10:0] ptr;
  logic        sda_bus;

  assign sda_bus = sda_m & (sda_t ? 1'b1 : sda_o);

  i2c_fram_target #(.DEV_TYPE(4'b1010), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_o(sda_o), .sda_t(sda_t), .busy(busy), .wr_strobe(wr_strobe), .ptr(ptr)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   sda_low_seen = 1'b0;
  logic sda_t_prev = 1'b1;

  logic [7:0] mem_m [2048];
  bit         known [2048];
  int         ptr_m = 0;
  logic [7:0] wdata [8];

  always @(posedge clk) begin
    if (scl_m) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // SDA may only move while SCL is low, 3 clk of sync/detect plus HOLD after SCL fell.
  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (!sda_t) sda_low_seen = 1'b1;
    if (mon_en && sda_t !== sda_t_prev) begin
      checks++;
      assert (scl_m === 1'b0 && cyc == 3 + HOLD) else begin
        errors++;
        $error("FAIL sda_t_timing: observed scl=%0b cyc=%0d required scl=0 cyc=%0d", scl_m, cyc, 3 + HOLD);
      end
    end
    sda_t_prev = sda_t;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    s = sda_bus;  tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(mack, s);
  endtask

  task automatic write_burst(input int addr, input int n);
    logic        ack;
    logic [10:0] a;
    int          s0;
    a  = addr[10:0];
    s0 = strobe_cnt;
    i2c_start();
    send_byte({4'hA, a[10:8], 1'b0}, ack); chk("wr_dev_ack", ack, 0);
    send_byte(a[7:0], ack);                chk("wr_word_ack", ack, 0);
    ptr_m = a;
    for (int i = 0; i < n; i++) begin
      send_byte(wdata[i], ack); chk("wr_data_ack", ack, 0);
      mem_m[ptr_m] = wdata[i];
      known[ptr_m] = 1'b1;
      ptr_m = (ptr_m + 1) % 2048;
    end
    chk("wr_busy", busy, 1);
    i2c_stop(); tick(4);
    chk("wr_strobes", strobe_cnt - s0, n);
    chk("wr_ptr", ptr, ptr_m);
    chk("wr_busy_after_stop", busy, 0);
  endtask

  task automatic read_burst(input int addr, input int n);
    logic        ack;
    logic [10:0] a;
    logic [7:0]  b;
    a = addr[10:0];
    i2c_start();
    send_byte({4'hA, a[10:8], 1'b0}, ack); chk("rd_dev_w_ack", ack, 0);
    send_byte(a[7:0], ack);                chk("rd_word_ack", ack, 0);
    i2c_start();
    send_byte({4'hA, a[10:8], 1'b1}, ack); chk("rd_dev_r_ack", ack, 0);
    ptr_m = a;
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1) ? 1'b1 : 1'b0, b);
      if (known[ptr_m]) chk("rd_data", b, mem_m[ptr_m]);
      ptr_m = (ptr_m + 1) % 2048;
    end
    i2c_stop(); tick(4);
    chk("rd_ptr", ptr, ptr_m);
    chk("rd_busy_after_stop", busy, 0);
  endtask

  initial begin
    logic ack, s;
    int   s0;
    for (int i = 0; i < 2048; i++) known[i] = 1'b0;

    rst = 1'b0; tick(4);
    chk("reset_sda_t", sda_t, 1);
    chk("reset_sda_o", sda_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_strobe", wr_strobe, 0);
    chk("reset_ptr", ptr, 0);
    rst = 1'b1; tick(4);
    mon_en = 1'b1;

    for (int i = 0; i < 4; i++) wdata[i] = 8'hA5;
    write_burst(11'h005, 4);
    read_burst(11'h005, 4);

    wdata[0] = 8'h11; wdata[1] = 8'h22;
    write_burst(11'h7FF, 2);
    chk("wrap_ptr", ptr, 11'h001);
    read_burst(11'h7FF, 2);

    s0 = strobe_cnt;
    i2c_start();
    sda_low_seen = 1'b0;
    send_byte(8'h90, ack); chk("mismatch_nack", ack, 1);
    chk("mismatch_busy", busy, 0);
    send_byte(8'h55, ack); chk("mismatch_ignored", ack, 1);
    i2c_stop(); tick(4);
    chk("mismatch_no_drive", sda_low_seen, 0);
    chk("mismatch_no_strobe", strobe_cnt - s0, 0);

    wdata[0] = 8'h3C;
    write_burst(11'h010, 1);
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'hA0, ack); chk("abort_dev_ack", ack, 0);
    send_byte(8'h10, ack); chk("abort_word_ack", ack, 0);
    for (int i = 0; i < 4; i++) clk_bit(i[0], s);
    i2c_stop(); tick(4);
    chk("abort_no_strobe", strobe_cnt - s0, 0);
    chk("abort_ptr", ptr, 11'h010);
    read_burst(11'h010, 1);

    for (int k = 0; k < 4; k++) begin
      int a, n;
      a = $urandom_range(0, 2047);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
      write_burst(a, n);
      read_burst(a, n);
    end

    wdata[0] = 8'h00; wdata[1] = 8'h80;
    write_burst(11'h123, 2);
    i2c_start();
    send_byte(8'hA2, ack); chk("midrd_dev_ack", ack, 0);
    send_byte(8'h23, ack); chk("midrd_word_ack", ack, 0);
    i2c_start();
    send_byte(8'hA3, ack); chk("midrd_rd_ack", ack, 0);
    chk("midrd_driving_low", sda_t, 0);
    mon_en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrd_reset_sda_t", sda_t, 1);
    chk("midrd_reset_ptr", ptr, 0);
    chk("midrd_reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(4);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    mon_en = 1'b1;
    read_burst(11'h124, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
